// File: rtl/dff_en.sv
// ---------------------------------------------------------------------------
// dff_en
//
// Purpose
//   Enable-gated D flip-flop. This is the storage primitive under register64
//   and the pipeline registers. One instance per bit in register64; setting
//   WIDTH above 1 lets a single instance hold a whole bus.
//
//   Each posedge of clk applies exactly one rule, highest priority first:
//     reset == 0            -> q <= RESET_VAL
//     reset == 1, en == 1   -> q <= d
//     reset == 1, en == 0   -> q <= q (hold)
//
//   Reset is synchronous and active-low. There is no asynchronous path, so a
//   reset pulse that starts and ends between two edges has no effect. q is a
//   pure register output with no combinational path from d or en.
//
// Parameters
//   WIDTH      stored bits, must be at least 1
//   RESET_VAL  value loaded into q on reset (WIDTH bits)
//   DELAY      clk-to-q delay in ns for simulation models; it has no effect
//              on the synthesized register
//
// Ports
//   clk       in   1      clock, all state updates on posedge
//   reset     in   1      synchronous active-low reset (0 = reset)
//   d         in   WIDTH  data to capture
//   en        in   1      load enable, active-high
//   q         out  WIDTH  registered output
//
// Optional scan chain (macro DFF_EN_SCAN_EN)
//   When DFF_EN_SCAN_EN is defined three extra ports appear:
//     scan_en   in   1  scan mode select
//     scan_in   in   1  serial scan data in
//     scan_out  out  1  equals q[WIDTH-1]
//   Priority becomes reset > scan_en > en. In scan mode the register shifts
//   towards the MSB with scan_in entering at bit 0; with WIDTH == 1 it simply
//   loads scan_in. With the macro undefined the ports do not exist and the
//   table above is the whole behaviour.
// ---------------------------------------------------------------------------

`timescale 1ns/10ps

module dff_en #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter real              DELAY     = 0.05
) (
`ifdef DFF_EN_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
`endif
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Elaboration-time sanity checks: a zero-width register is meaningless and
  // a negative clk-to-q delay cannot be modelled.
  if (WIDTH < 1) begin : g_width_check
    $error("dff_en: WIDTH must be at least 1");
  end

  if (DELAY < 0.0) begin : g_delay_check
    $error("dff_en: DELAY must not be negative");
  end

`ifdef DFF_EN_SCAN_EN
  logic [WIDTH-1:0] shift_d;

  // Scan shift value. A one-bit register has no lower bits to shift up, so
  // it just takes scan_in directly.
  if (WIDTH == 1) begin : g_shift_single
    assign shift_d = scan_in;
  end else begin : g_shift_multi
    assign shift_d = {q_q[WIDTH-2:0], scan_in};
  end

  assign scan_out = q_q[WIDTH-1];
`endif

  // Next-state selection. The enable mux is a ternary rather than an if so
  // that an X on en propagates to q in simulation instead of being silently
  // treated as a hold.
  always_comb begin
    q_d = en ? d : q_q;
`ifdef DFF_EN_SCAN_EN
    if (scan_en) begin
      q_d = shift_d;
    end
`endif
  end

  // State register with synchronous active-low reset; reset beats every
  // other source on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_dff_en.sv
// ---------------------------------------------------------------------------
// tb_dff_en
//
// Directed testbench for dff_en. Two instances share the control inputs:
//   dut   WIDTH=4, RESET_VAL=4'h0 (main target)
//   dut1  WIDTH=1, RESET_VAL=1'b1 (non-zero reset value, d = d[0])
// Inputs change on the falling edge; outputs are sampled 1ns after the
// rising edge. Build with +define+DFF_EN_SCAN_EN to also exercise scan.
// ---------------------------------------------------------------------------

`timescale 1ns/10ps

module tb_dff_en;

  logic       clk;
  logic       resetN;
  logic [3:0] d;
  logic       en;
  logic [3:0] q;
  logic       q1;

  logic       scanEn;
  logic       scanIn;
  logic       scanOut;
  logic       scanOut1;

  int checks;
  int errors;

  logic [3:0] expQ;
  logic       expQ1;

  dff_en #(
    .WIDTH    (4),
    .RESET_VAL(4'h0)
  ) dut (
`ifdef DFF_EN_SCAN_EN
    .scan_en (scanEn),
    .scan_in (scanIn),
    .scan_out(scanOut),
`endif
    .clk     (clk),
    .reset   (resetN),
    .d       (d),
    .en      (en),
    .q       (q)
  );

  dff_en #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) dut1 (
`ifdef DFF_EN_SCAN_EN
    .scan_en (scanEn),
    .scan_in (scanIn),
    .scan_out(scanOut1),
`endif
    .clk     (clk),
    .reset   (resetN),
    .d       (d[0:0]),
    .en      (en),
    .q       (q1)
  );

  // 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs on the falling edge, then advance past the next rising
  // edge so the outputs are settled when checked.
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] dv);
    @(negedge clk);
    resetN = r;
    en     = e;
    d      = dv;
    @(posedge clk);
    #1;
  endtask

  // Compare both instances against the expected values.
  task automatic checkOutput(input string tag, input logic [3:0] exp4, input logic exp1);
    checks++;
    assert (q === exp4) else begin
      errors++;
      $error("[TB] FAIL %s: q=%h expected %h", tag, q, exp4);
    end
    checks++;
    assert (q1 === exp1) else begin
      errors++;
      $error("[TB] FAIL %s_w1: q1=%b expected %b", tag, q1, exp1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b1;
    en     = 1'b0;
    d      = 4'h0;
    scanEn = 1'b0;
    scanIn = 1'b0;

    // 1. reset, then hold with en low
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkOutput("reset", 4'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'h0);
    checkOutput("post_reset_hold", 4'h0, 1'b1);

    // 2. loads
    applyStimulus(1'b1, 1'b1, 4'hA);
    checkOutput("load_A", 4'hA, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h3);
    checkOutput("load_3", 4'h3, 1'b1);

    // 3. hold for two edges with different d, then load
    applyStimulus(1'b1, 1'b0, 4'hC);
    checkOutput("hold_1", 4'h3, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'hC);
    checkOutput("hold_2", 4'h3, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'hC);
    checkOutput("load_C", 4'hC, 1'b0);

    // 4. reset beats en on the same edge
    applyStimulus(1'b0, 1'b1, 4'h5);
    checkOutput("reset_wins", 4'h0, 1'b1);

    // reload, then pulse reset low strictly between edges
    applyStimulus(1'b1, 1'b1, 4'h6);
    checkOutput("load_6", 4'h6, 1'b0);
    @(negedge clk);
    en     = 1'b0;
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("glitch_reset_ignored", 4'h6, 1'b0);

    // 5. pseudo-random data with toggling enable against a load/hold model
    expQ  = 4'h6;
    expQ1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] rd;
      logic       re;
      rd = 4'($urandom_range(0, 15));
      re = (i % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      applyStimulus(1'b1, re, rd);
      if (re) begin
        expQ  = rd;
        expQ1 = rd[0];
      end
      checkOutput($sformatf("random_%0d", i), expQ, expQ1);
    end

`ifdef DFF_EN_SCAN_EN
    // 6. scan shift from a cleared register; en and d must be ignored
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkOutput("scan_pre_reset", 4'h0, 1'b1);
    scanEn = 1'b1;
    scanIn = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'hF);
    checkOutput("scan_1", 4'b0001, 1'b1);
    scanIn = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'hF);
    checkOutput("scan_2", 4'b0010, 1'b0);
    scanIn = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'hF);
    checkOutput("scan_3", 4'b0101, 1'b1);
    scanIn = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0);
    checkOutput("scan_4", 4'b1011, 1'b1);
    checks++;
    assert (scanOut === 1'b1) else begin
      errors++;
      $error("[TB] FAIL scan_out: scan_out=%b expected 1", scanOut);
    end
    checks++;
    assert (scanOut1 === 1'b1) else begin
      errors++;
      $error("[TB] FAIL scan_out_w1: scan_out=%b expected 1", scanOut1);
    end
    // reset still wins over scan
    applyStimulus(1'b0, 1'b1, 4'hF);
    checkOutput("scan_reset_wins", 4'h0, 1'b1);
    scanEn = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
